// File: rtl/posit_adder_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable posit adder among NREQ requesters.
// A tag shift register that mirrors the adder pipeline routes each result back to its issuer.
module posit_adder_arbiter #(
    parameter int N       = 32,
    parameter int ES      = 2,
    parameter int NREQ    = 4,
    parameter int LATENCY = 6
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_inf,
    output logic              rsp_zero,
    output logic              add_start,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    input  logic [N-1:0]      add_result,
    input  logic              add_inf,
    input  logic              add_zero,
    input  logic              add_done,
    output logic [7:0]        inflight,
    output logic              err
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int QW  = $clog2(LATENCY + 2);

    if (NREQ < 2 || NREQ > 16 || LATENCY < 1 || ES < 0 || ES >= N) begin : g_bad_params
        $error("posit_adder_arbiter: parameter out of range");
    end

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] issueId_q;
    logic           addStart_q;
    logic [N-1:0]   addIn1_q;
    logic [N-1:0]   addIn2_q;
    logic [LATENCY:0] tagValid_q;
    logic [IDW-1:0] tagId_q [LATENCY+1];
    logic [NREQ-1:0] rspValid_q;
    logic [N-1:0]   rspResult_q;
    logic           rspInf_q;
    logic           rspZero_q;
    logic [7:0]     inflight_q;
    logic [7:0]     inflight_d;
    logic           err_q;
    logic [QW-1:0]  quiet_q;

    logic           gntAny;
    logic [IDW-1:0] gntIdx;
    logic [IDW-1:0] candIdx;
    logic           rspFire;
    logic           protoErr;

    always_comb begin
        gntAny  = 1'b0;
        gntIdx  = '0;
        candIdx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            candIdx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gntAny && req_valid[candIdx]) begin
                gntAny = 1'b1;
                gntIdx = candIdx;
            end
        end
        if (areset) begin
            gntAny = 1'b0;
            gntIdx = '0;
        end
    end

    assign req_ready = gntAny ? (NREQ'(1) << gntIdx) : '0;

    // After reset the adder may still deliver dones for discarded ops; they are ignored
    // until a freshly issued op could first reach the aligned tag stage.
    always_comb begin
        rspFire    = tagValid_q[LATENCY] && add_done;
        protoErr   = (tagValid_q[LATENCY] != add_done) && (quiet_q == '0);
        inflight_d = inflight_q;
        if (gntAny && !rspFire && inflight_q != 8'hFF) begin
            inflight_d = inflight_q + 8'd1;
        end else if (rspFire && !gntAny && inflight_q != 8'h00) begin
            inflight_d = inflight_q - 8'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q       <= IDW'(NREQ - 1);
            issueId_q   <= '0;
            addStart_q  <= 1'b0;
            addIn1_q    <= '0;
            addIn2_q    <= '0;
            tagValid_q  <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tagId_q[s] <= '0;
            end
            rspValid_q  <= '0;
            rspResult_q <= '0;
            rspInf_q    <= 1'b0;
            rspZero_q   <= 1'b0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            quiet_q     <= QW'(LATENCY + 1);
        end else begin
            addStart_q <= gntAny;
            if (gntAny) begin
                ptr_q     <= gntIdx;
                issueId_q <= gntIdx;
                addIn1_q  <= req_in1[gntIdx*N +: N];
                addIn2_q  <= req_in2[gntIdx*N +: N];
            end
            tagValid_q <= {tagValid_q[LATENCY-1:0], addStart_q};
            tagId_q[0] <= issueId_q;
            for (int s = 1; s <= LATENCY; s++) begin
                tagId_q[s] <= tagId_q[s-1];
            end
            rspValid_q <= rspFire ? (NREQ'(1) << tagId_q[LATENCY]) : '0;
            if (rspFire) begin
                rspResult_q <= add_result;
                rspInf_q    <= add_inf;
                rspZero_q   <= add_zero;
            end
            inflight_q <= inflight_d;
            if (protoErr) begin
                err_q <= 1'b1;
            end
            if (quiet_q != '0) begin
                quiet_q <= quiet_q - QW'(1);
            end
        end
    end

    assign add_start  = addStart_q;
    assign add_in1    = addIn1_q;
    assign add_in2    = addIn2_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = rspResult_q;
    assign rsp_inf    = rspInf_q;
    assign rsp_zero   = rspZero_q;
    assign inflight   = inflight_q;
    assign err        = err_q;

endmodule

// File: tb/tb_posit_adder_arbiter.sv
// Bench for posit_adder_arbiter: table of grant vectors plus hand-written reset/error sequences,
// with a stand-in fixed-latency adder and a response scoreboard keyed by due cycle.
module tb_posit_adder_arbiter;
    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int LATENCY = 6;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_in1;
    logic [NREQ*N-1:0] req_in2;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_result;
    logic              rsp_inf;
    logic              rsp_zero;
    logic              add_start;
    logic [N-1:0]      add_in1;
    logic [N-1:0]      add_in2;
    logic [N-1:0]      add_result;
    logic              add_inf;
    logic              add_zero;
    logic              add_done;
    logic [7:0]        inflight;
    logic              err;

    posit_adder_arbiter #(.N(N), .ES(2), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
        .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .inflight(inflight), .err(err)
    );

    always #5 aclk = ~aclk;

    // Stand-in adder: exact only for 1.0+1.0, otherwise an arbitrary but traceable mix.
    function automatic logic [31:0] addModel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    logic [LATENCY:0] mDone = '0;
    logic [31:0]      mRes [LATENCY+1];
    bit               earlyDone = 1'b0;

    always @(posedge aclk) begin
        mDone   <= {mDone[LATENCY-1:0], add_start};
        mRes[0] <= addModel(add_in1, add_in2);
        for (int k = 1; k <= LATENCY; k++) mRes[k] <= mRes[k-1];
    end

    assign add_done   = earlyDone ? mDone[LATENCY-1] : mDone[LATENCY];
    assign add_result = earlyDone ? mRes[LATENCY-1] : mRes[LATENCY];
    assign add_inf    = (add_result == 32'h8000_0000);
    assign add_zero   = (add_result == 32'h0000_0000);

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [31:0] res;
        logic        inf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] expReady;
        bit         special;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   tickNo = 0;
    int   inflModel = 0;
    int   peakSeen = 0;
    bit   expErr = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tickNo);
        end
    endtask

    task automatic loadOps(input bit special);
        logic [31:0] x;
        for (int i = 0; i < NREQ; i++) begin
            req_in1[i*N +: N] = 32'(32'h0100_0000 * (i + 1) + tickNo * 16);
            req_in2[i*N +: N] = 32'(32'h0003_0000 * (i + 1) + tickNo);
        end
        if (special) begin
            x = req_in1[1*N +: N];
            req_in2[1*N +: N] = {x[15:0], x[31:16]};
            req_in1[2*N +: N] = 32'h8000_0000;
            req_in2[2*N +: N] = 32'h0000_0000;
        end
    endtask

    // One clock: check the grant just before the edge, then everything registered at it.
    task automatic applyStimulus(input logic [3:0] expReady, input bit noRsp);
        logic [3:0]  hs;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        exp_t        e;
        int          id;
        tickNo++;
        #1;
        checkOutput("req_ready", 64'(req_ready), 64'(expReady));
        hs = req_valid & req_ready;
        id = -1;
        a = '0;
        b = '0;
        for (int i = 0; i < NREQ; i++) if (hs[i]) id = i;
        if (id >= 0) begin
            a = req_in1[id*N +: N];
            b = req_in2[id*N +: N];
            r = addModel(a, b);
            if (!noRsp) begin
                e.due  = tickNo + LATENCY + 2;
                e.id   = 2'(id);
                e.res  = r;
                e.inf  = (r == 32'h8000_0000);
                e.zero = (r == 32'h0000_0000);
                expQ.push_back(e);
            end
            inflModel++;
        end
        @(negedge aclk);
        checkOutput("add_start", 64'(add_start), 64'(id >= 0));
        if (id >= 0) begin
            checkOutput("add_in1", 64'(add_in1), 64'(a));
            checkOutput("add_in2", 64'(add_in2), 64'(b));
        end
        if (expQ.size() > 0 && expQ[0].due == tickNo) begin
            e = expQ.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
            checkOutput("rsp_result", 64'(rsp_result), 64'(e.res));
            checkOutput("rsp_inf", 64'(rsp_inf), 64'(e.inf));
            checkOutput("rsp_zero", 64'(rsp_zero), 64'(e.zero));
            inflModel--;
        end else begin
            checkOutput("rsp_idle", 64'(rsp_valid), 64'(0));
        end
        checkOutput("inflight", 64'(inflight), 64'(inflModel));
        checkOutput("err", 64'(err), 64'(expErr));
        if (int'(inflight) > peakSeen) peakSeen = int'(inflight);
    endtask

    initial begin
        areset    = 1'b1;
        req_valid = 4'b1111;
        req_in1   = '0;
        req_in2   = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
            checkOutput("rst_add_start", 64'(add_start), 64'(0));
            checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            checkOutput("rst_inflight", 64'(inflight), 64'(0));
            checkOutput("rst_err", 64'(err), 64'(0));
        end
        areset    = 1'b0;
        req_valid = 4'b0000;

        // Single op 1.0 + 1.0 from requester 2.
        loadOps(1'b0);
        req_in1[2*N +: N] = 32'h4000_0000;
        req_in2[2*N +: N] = 32'h4000_0000;
        req_valid = 4'b0100;
        applyStimulus(4'b0100, 1'b0);
        req_valid = 4'b0000;
        for (int c = 0; c < LATENCY + 3; c++) applyStimulus(4'b0000, 1'b0);
        checkOutput("single_result", 64'(rsp_result), 64'h4800_0000);

        vecs.push_back('{4'b1000, 4'b1000, 1'b0});
        for (int k = 0; k < 12; k++) vecs.push_back('{4'b1111, 4'(1 << (k % 4)), 1'b0});
        for (int k = 0; k < 10; k++) vecs.push_back('{4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{4'b0110, 4'b0010, 1'b1});
        vecs.push_back('{4'b0110, 4'b0100, 1'b1});
        vecs.push_back('{4'b0110, 4'b0010, 1'b1});
        for (int k = 0; k < 10; k++) vecs.push_back('{4'b0000, 4'b0000, 1'b0});
        foreach (vecs[v]) begin
            req_valid = vecs[v].valid;
            loadOps(vecs[v].special);
            applyStimulus(vecs[v].expReady, 1'b0);
        end
        checkOutput("inflight_peak", 64'(peakSeen), 64'(LATENCY + 2));

        // Reset while three ops are in flight; the adder keeps going and must be ignored.
        req_valid = 4'b1111;
        loadOps(1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        areset    = 1'b1;
        req_valid = 4'b0000;
        expQ.delete();
        inflModel = 0;
        applyStimulus(4'b0000, 1'b0);
        areset = 1'b0;
        for (int c = 0; c < 12; c++) applyStimulus(4'b0000, 1'b0);

        // Adder reports done one cycle early: sticky err, no response for the op.
        earlyDone = 1'b1;
        req_valid = 4'b0001;
        loadOps(1'b0);
        applyStimulus(4'b0001, 1'b1);
        req_valid = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            expErr = (k >= LATENCY + 1);
            applyStimulus(4'b0000, 1'b0);
        end
        checkOutput("err_sticky", 64'(err), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
